// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
// The sub line exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    modport master (
        output start, op_a, op_b,
`ifdef SERIAL_ADD_SUB_EN
        output sub,
`endif
        input  busy, done, sum, carry_out
    );

    modport slave (
        input  start, op_a, op_b,
`ifdef SERIAL_ADD_SUB_EN
        input  sub,
`endif
        output busy, done, sum, carry_out
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-add cell built from two half adders, LSB first.
// Define SERIAL_ADD_SUB_EN to add the sub input (a - b via ~b and carry-in of 1).
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_add_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             cy;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_r;
    logic             carry_out_r;
    logic             busy_r;
    logic             done_r;
    logic             sub_in;

    logic s1, c1, c2, bit_sum, bit_carry;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_in = bus.sub;
`else
    assign sub_in = 1'b0;
`endif

    // Two half adders form the shared full-add cell.
    assign s1        = a_sr[0] ^ b_sr[0];
    assign c1        = a_sr[0] & b_sr[0];
    assign bit_sum   = s1 ^ cy;
    assign c2        = s1 & cy;
    assign bit_carry = c1 | c2;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_sr        <= '0;
            b_sr        <= '0;
            cy          <= 1'b0;
            cnt         <= '0;
            sum_r       <= '0;
            carry_out_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_sr        <= bus.op_a;
                        b_sr        <= sub_in ? ~bus.op_b : bus.op_b;
                        cy          <= sub_in;
                        cnt         <= '0;
                        sum_r       <= '0;
                        carry_out_r <= 1'b0;
                        busy_r      <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    sum_r <= {bit_sum, sum_r[WIDTH-1:1]};
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    cy    <= bit_carry;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        carry_out_r <= bit_carry;
                        done_r      <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.sum       = sum_r;
    assign bus.carry_out = carry_out_r;
endmodule
